// File: rtl/food_arbiter_if.sv
// Bundles the food arbiter's game-side signals.
//   master: game/movement/collision side (drives tick, heads, rand_in, cand_occ)
//   slave : food_arbiter (drives cand, food, food_valid, scores, eat pulses, busy, no_space)
interface food_arbiter_if #(
  parameter int unsigned num_len         = 10,
  parameter int unsigned max_len_bit_len = 4
);
  logic                       tick;
  logic [num_len-1:0]         head_a;
  logic [num_len-1:0]         head_b;
  logic [num_len-1:0]         rand_in;
  logic [num_len-1:0]         cand;
  logic                       cand_occ;
  logic [num_len-1:0]         food;
  logic                       food_valid;
  logic [max_len_bit_len-1:0] score_a;
  logic [max_len_bit_len-1:0] score_b;
  logic                       eat_a;
  logic                       eat_b;
  logic                       busy;
  logic                       no_space;

  modport master (
    output tick, head_a, head_b, rand_in, cand_occ,
    input  cand, food, food_valid, score_a, score_b, eat_a, eat_b, busy, no_space
  );

  modport slave (
    input  tick, head_a, head_b, rand_in, cand_occ,
    output cand, food, food_valid, score_a, score_b, eat_a, eat_b, busy, no_space
  );
endinterface

// File: rtl/food_arbiter.sv
// Awards a shared food item to one of two snakes on each game tick (round-robin
// on ties), then places new food: random draws from an external LFSR first,
// falling back to a linear scan of the grid, rejecting occupied/out-of-range cells.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : food_arbiter_if.slave (tick, heads, rand_in, cand/cand_occ query,
//              food/food_valid, scores, eat pulses, busy, sticky no_space)
module food_arbiter #(
  parameter int unsigned num_len         = 10,
  parameter int unsigned max_len_bit_len = 4,
  parameter int unsigned grid_cells      = 800,
  parameter int unsigned max_retry       = 8,
  parameter int unsigned init_food       = 37
) (
  input logic           clk,
  input logic           rst,
  food_arbiter_if.slave bus
);

  localparam int unsigned RETRY_W = $clog2(max_retry + 1);
  localparam int unsigned SCAN_W  = $clog2(grid_cells + 1);
  localparam logic [num_len:0]           GRID       = (num_len + 1)'(grid_cells);
  localparam logic [RETRY_W-1:0]         RETRY_LAST = RETRY_W'(max_retry - 1);
  localparam logic [SCAN_W-1:0]          SCAN_LAST  = SCAN_W'(grid_cells - 1);
  localparam logic [max_len_bit_len-1:0] SCORE_MAX  = '1;
  localparam logic [num_len-1:0]         FOOD_RST   = num_len'(init_food);

  typedef enum logic [1:0] {IDLE, PICK, TEST, SCAN} state_t;

  state_t                     state_q, state_d;
  logic [num_len-1:0]         cand_q, cand_d;
  logic [num_len-1:0]         food_q, food_d;
  logic                       food_valid_q, food_valid_d;
  logic [max_len_bit_len-1:0] score_a_q, score_a_d;
  logic [max_len_bit_len-1:0] score_b_q, score_b_d;
  logic                       eat_a_q, eat_a_d;
  logic                       eat_b_q, eat_b_d;
  logic                       busy_q, busy_d;
  logic                       no_space_q, no_space_d;
  logic [RETRY_W-1:0]         retry_q, retry_d;
  logic [SCAN_W-1:0]          scan_q, scan_d;
  logic                       prio_b_q, prio_b_d;   // 1: snake B wins the next tie
  logic                       in_scan_q, in_scan_d; // placement is in linear-scan phase

  logic               hit_a, hit_b, award_a, award_b, cand_ok;
  logic [num_len:0]   cand_inc;

  // Eat arbitration: a tie goes to the priority holder.
  assign hit_a   = (bus.head_a == food_q);
  assign hit_b   = (bus.head_b == food_q);
  assign award_a = hit_a && (!hit_b || !prio_b_q);
  assign award_b = hit_b && (!hit_a || prio_b_q);

  // Candidate check uses live heads, so a head stepping onto cand rejects it.
  assign cand_ok = ({1'b0, cand_q} < GRID) && (cand_q != bus.head_a) &&
                   (cand_q != bus.head_b) && !bus.cand_occ;
  assign cand_inc = {1'b0, cand_q} + (num_len + 1)'(1);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      food_q       <= FOOD_RST;
      food_valid_q <= 1'b1;
      score_a_q    <= '0;
      score_b_q    <= '0;
      eat_a_q      <= 1'b0;
      eat_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      no_space_q   <= 1'b0;
      retry_q      <= '0;
      scan_q       <= '0;
      prio_b_q     <= 1'b0;
      in_scan_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      food_q       <= food_d;
      food_valid_q <= food_valid_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      eat_a_q      <= eat_a_d;
      eat_b_q      <= eat_b_d;
      busy_q       <= busy_d;
      no_space_q   <= no_space_d;
      retry_q      <= retry_d;
      scan_q       <= scan_d;
      prio_b_q     <= prio_b_d;
      in_scan_q    <= in_scan_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    food_d       = food_q;
    food_valid_d = food_valid_q;
    score_a_d    = score_a_q;
    score_b_d    = score_b_q;
    eat_a_d      = 1'b0;
    eat_b_d      = 1'b0;
    no_space_d   = no_space_q;
    retry_d      = retry_q;
    scan_d       = scan_q;
    prio_b_d     = prio_b_q;
    in_scan_d    = in_scan_q;

    case (state_q)
      IDLE: begin
        if (bus.tick && food_valid_q && (hit_a || hit_b)) begin
          if (hit_a && hit_b) prio_b_d = !prio_b_q;
          if (award_a) begin
            eat_a_d   = 1'b1;
            score_a_d = (score_a_q == SCORE_MAX) ? score_a_q
                                                 : score_a_q + max_len_bit_len'(1);
          end
          if (award_b) begin
            eat_b_d   = 1'b1;
            score_b_d = (score_b_q == SCORE_MAX) ? score_b_q
                                                 : score_b_q + max_len_bit_len'(1);
          end
          food_valid_d = 1'b0;
          retry_d      = '0;
          in_scan_d    = 1'b0;
          state_d      = PICK;
        end
      end
      PICK: begin
        cand_d  = bus.rand_in;
        state_d = TEST;
      end
      TEST: begin
        if (cand_ok) begin
          food_d       = cand_q;
          food_valid_d = 1'b1;
          state_d      = IDLE;
        end else if (!in_scan_q) begin
          if (retry_q == RETRY_LAST) begin
            scan_d    = '0;
            in_scan_d = 1'b1;
            state_d   = SCAN;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = PICK;
          end
        end else begin
          if (scan_q == SCAN_LAST) begin
            no_space_d   = 1'b1;
            food_valid_d = 1'b0;
            state_d      = IDLE;
          end else begin
            scan_d  = scan_q + SCAN_W'(1);
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        cand_d  = (cand_inc >= GRID) ? '0 : cand_inc[num_len-1:0];
        state_d = TEST;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.cand       = cand_q;
  assign bus.food       = food_q;
  assign bus.food_valid = food_valid_q;
  assign bus.score_a    = score_a_q;
  assign bus.score_b    = score_b_q;
  assign bus.eat_a      = eat_a_q;
  assign bus.eat_b      = eat_b_q;
  assign bus.busy       = busy_q;
  assign bus.no_space   = no_space_q;

endmodule

// File: tb/tb_food_arbiter.sv
// Directed self-checking bench for food_arbiter.
module tb_food_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  food_arbiter_if #(.num_len(10), .max_len_bit_len(4)) bus();

  food_arbiter #(
    .num_len(10), .max_len_bit_len(4), .grid_cells(800),
    .max_retry(8), .init_food(37)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Occupancy model: either everything but free_cell is occupied, or only occ_cell.
  logic       occ_all   = 1'b0;
  logic [9:0] occ_cell  = 10'd1023;
  logic [9:0] free_cell = 10'd1023;
  assign bus.cand_occ = occ_all ? (bus.cand != free_cell) : (bus.cand == occ_cell);

  int checks = 0;
  int errors = 0;
  int n;
  int exp_a;
  int vals [4];
  logic [9:0] cur_food;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_food"},       32'(bus.food),       37);
    check({tag, "_food_valid"}, 32'(bus.food_valid), 1);
    check({tag, "_cand"},       32'(bus.cand),       0);
    check({tag, "_score_a"},    32'(bus.score_a),    0);
    check({tag, "_score_b"},    32'(bus.score_b),    0);
    check({tag, "_eat"},        32'({bus.eat_a, bus.eat_b}), 0);
    check({tag, "_busy"},       32'(bus.busy),       0);
    check({tag, "_no_space"},   32'(bus.no_space),   0);
  endtask

  // Reset asserted between clock edges; outputs must change without an edge.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check({tag, "_rel_food"},  32'(bus.food),       37);
    check({tag, "_rel_valid"}, 32'(bus.food_valid), 1);
    check({tag, "_rel_busy"},  32'(bus.busy),       0);
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  initial begin
    bus.tick    = 1'b0;
    bus.head_a  = '0;
    bus.head_b  = '0;
    bus.rand_in = '0;

    // Power-on reset
    cyc();
    cyc();
    check_reset_vals("por");
    rst = 1'b0;
    cyc();

    // Single eat: A on food 37, new food at 200 three cycles after tick
    bus.head_a  = 10'd37;
    bus.head_b  = 10'd100;
    bus.rand_in = 10'd200;
    do_tick();
    check("single_eat_a",   32'(bus.eat_a),      1);
    check("single_eat_b",   32'(bus.eat_b),      0);
    check("single_score_a", 32'(bus.score_a),    1);
    check("single_score_b", 32'(bus.score_b),    0);
    check("single_busy",    32'(bus.busy),       1);
    check("single_fv0",     32'(bus.food_valid), 0);
    cyc();
    check("single_eat_once", 32'(bus.eat_a), 0);
    check("single_cand",     32'(bus.cand),  200);
    cyc();
    check("single_food",  32'(bus.food),       200);
    check("single_fv1",   32'(bus.food_valid), 1);
    check("single_idle",  32'(bus.busy),       0);

    // Tie-break from a fresh reset: A wins first tie, B the second
    mid_reset("rst1");
    bus.head_a  = 10'd37;
    bus.head_b  = 10'd37;
    bus.rand_in = 10'd50;
    do_tick();
    check("tie1_eat_a", 32'(bus.eat_a), 1);
    check("tie1_eat_b", 32'(bus.eat_b), 0);
    cyc();
    cyc();
    check("tie1_food", 32'(bus.food), 50);
    bus.head_a  = 10'd50;
    bus.head_b  = 10'd50;
    bus.rand_in = 10'd60;
    do_tick();
    check("tie2_eat_a", 32'(bus.eat_a), 0);
    check("tie2_eat_b", 32'(bus.eat_b), 1);
    cyc();
    cyc();
    check("tie2_food",    32'(bus.food),    60);
    check("tie2_score_a", 32'(bus.score_a), 1);
    check("tie2_score_b", 32'(bus.score_b), 1);

    // Rejection: out of range, on head_b, occupied, then free
    bus.head_a  = 10'd60;
    bus.head_b  = 10'd5;
    occ_cell    = 10'd6;
    vals        = '{900, 5, 6, 7};
    bus.rand_in = 10'(vals[0]);
    do_tick();
    check("rej_eat_a",   32'(bus.eat_a),   1);
    check("rej_score_a", 32'(bus.score_a), 2);
    for (int i = 0; i < 4; i++) begin
      bus.rand_in = 10'(vals[i]);
      cyc();
      check($sformatf("rej_cand%0d", i), 32'(bus.cand), 32'(vals[i]));
      cyc();
      if (i < 3) begin
        check($sformatf("rej_fv%0d", i),  32'(bus.food_valid), 0);
        check($sformatf("rej_eat%0d", i), 32'({bus.eat_a, bus.eat_b}), 0);
      end
    end
    check("rej_food", 32'(bus.food),       7);
    check("rej_fv",   32'(bus.food_valid), 1);
    check("rej_busy", 32'(bus.busy),       0);
    occ_cell = 10'd1023;

    // Scan fallback: all draws occupied, last draw 10, only cell 12 free
    bus.head_a = 10'd7;
    bus.head_b = 10'd500;
    occ_all    = 1'b1;
    free_cell  = 10'd12;
    bus.rand_in = 10'd100;
    do_tick();
    for (int i = 0; i < 8; i++) begin
      bus.rand_in = (i == 7) ? 10'd10 : 10'd100;
      cyc();
      cyc();
    end
    check("scan_busy", 32'(bus.busy), 1);
    cyc();
    check("scan_cand11", 32'(bus.cand), 11);
    cyc();
    cyc();
    check("scan_cand12", 32'(bus.cand), 12);
    cyc();
    check("scan_food",    32'(bus.food),       12);
    check("scan_fv",      32'(bus.food_valid), 1);
    check("scan_score_a", 32'(bus.score_a),    3);
    occ_all   = 1'b0;
    free_cell = 10'd1023;

    // Saturation: keep eating with A; score stops at 15 but eat still pulses
    exp_a    = 3;
    cur_food = 10'd12;
    bus.head_b = 10'd700;
    for (int k = 0; k < 13; k++) begin
      bus.head_a  = cur_food;
      bus.rand_in = 10'(300 + k);
      do_tick();
      exp_a = (exp_a == 15) ? 15 : exp_a + 1;
      check($sformatf("sat_eat%0d", k),   32'(bus.eat_a),   1);
      check($sformatf("sat_score%0d", k), 32'(bus.score_a), 32'(exp_a));
      cyc();
      cyc();
      check($sformatf("sat_food%0d", k), 32'(bus.food), 32'(300 + k));
      cur_food = 10'(300 + k);
    end

    // No space: every cell occupied; worst-case latency then sticky no_space
    bus.head_a  = cur_food;
    bus.rand_in = 10'd100;
    occ_all     = 1'b1;
    do_tick();
    check("ns_eat_a",   32'(bus.eat_a),   1);
    check("ns_score_a", 32'(bus.score_a), 15);
    n = 0;
    while (bus.busy && n < 2000) begin
      cyc();
      n++;
    end
    check("ns_latency",  32'(n),              1616);
    check("ns_no_space", 32'(bus.no_space),   1);
    check("ns_fv",       32'(bus.food_valid), 0);
    do_tick();
    check("ns_tick_busy", 32'(bus.busy),     0);
    check("ns_tick_eat",  32'(bus.eat_a),    0);
    check("ns_tick_sc",   32'(bus.score_a),  15);
    check("ns_sticky",    32'(bus.no_space), 1);
    mid_reset("rst2");

    // Async reset while scanning
    bus.head_a  = 10'd37;
    bus.rand_in = 10'd100;
    do_tick();
    for (int i = 0; i < 21; i++) cyc();
    check("mid_busy", 32'(bus.busy), 1);
    mid_reset("rst3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/food_arbiter.md
# food_arbiter

Sequences food placement for a two-snake game sharing one food item. On each game step it checks both snake heads against the current food, awards the point to exactly one snake (round-robin tie-break), then draws candidate positions from an external LFSR, rejecting occupied or out-of-range cells, and republishes the food. It sits between the snake movement logic, the body-collision checker (occupancy query), and the score/display path.

## Interface
- `num_len`, 10, width of a cell index.
- `max_len_bit_len`, 4, score width.
- `grid_cells`, 800, number of legal cells; valid indices are 0..grid_cells-1.
- `max_retry`, 8, random draws before falling back to linear scan.
- `init_food`, 10'd37, food cell after reset.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle game-step strobe.
- `head_a`, `head_b`  in  num_len  current head cells of snakes A and B.
- `rand_in`  in  num_len  free-running LFSR value.
- `cand`  out  num_len  registered candidate cell, driven to the collision checker.
- `cand_occ`  in  1  combinational: 1 if `cand` is covered by any snake body.
- `food`  out  num_len  current food cell.
- `food_valid`  out  1  food is placed and eatable.
- `score_a`, `score_b`  out  max_len_bit_len  per-snake scores.
- `eat_a`, `eat_b`  out  1  one-cycle pulse when the snake is awarded the food.
- `busy`  out  1  high in any state other than IDLE.
- `no_space`  out  1  sticky: placement failed, no free cell found.

## Operation
- Reset (async): state IDLE, `food`=init_food, `food_valid`=1, `cand`=0, scores 0, `eat_*`=0, retry/scan counters 0, priority=A, `no_space`=0.
- States: IDLE, PICK, TEST, SCAN.
- IDLE: on `tick` with `food_valid`=1: hit_a=(head_a==food), hit_b=(head_b==food).
  - Only one hit: that snake is awarded.
  - Both hit: snake holding priority is awarded; priority toggles. Priority is unchanged otherwise.
  - Award: score +1, saturating at 2^max_len_bit_len-1; `eat_x` pulses; `food_valid`<=0; retry<=0; go to PICK.
  - No hit: stay in IDLE, no outputs change.
- IDLE: `tick` with `food_valid`=0 (only after `no_space`) is ignored.
- PICK: `cand`<=`rand_in`; go to TEST.
- TEST: candidate valid iff cand<grid_cells, cand!=head_a, cand!=head_b, !cand_occ.
  - Valid: `food`<=cand, `food_valid`<=1, go to IDLE.
  - Invalid, in random phase: if retry==max_retry-1, scan<=0 and go to SCAN; otherwise retry+1 and go to PICK.
  - Invalid, in scan phase: if scan==grid_cells-1, set `no_space`=1 and go to IDLE with `food_valid`=0; otherwise scan+1 and go to SCAN.
- SCAN: `cand`<=cand+1, wrapping to 0 when cand+1>=grid_cells; go to TEST.
- `tick` while `busy` is ignored: no eat check and no queuing.
- Heads are sampled live in TEST, so a head moving onto the candidate in that cycle rejects it.

## Timing
- Eat decision is made at the `tick` edge. `eat_x` and the new score are visible the following cycle, and `busy` rises the same cycle.
- Best-case placement: `tick` at edge t; PICK at edge t+1; TEST accepts at edge t+2; `food_valid`=1 from cycle t+3.
- Each rejected random draw costs 2 cycles.
- Worst case before `no_space`: 2*max_retry + 2*grid_cells cycles.
- `cand_occ` must settle within one cycle of `cand` changing (combinational path only).
- Reset mid-placement: immediate return to reset values. The in-flight candidate is discarded; scores already awarded are cleared.

## Test plan
- Single eat: food=37, head_a=37, head_b=100, tick; rand_in=200, cand_occ=0 -> eat_a pulses once, score_a=1, score_b=0, food=200 with food_valid=1 three cycles after tick.
- Tie-break: both heads=37 on food=37, tick -> A awarded. Place food at 50; both heads=50, tick -> B awarded. Scores end 1/1.
- Rejection: rand_in=900 (≥800), then 5 (==head_b), then 6 with cand_occ=1, then 7 free -> food=7 after 4 draws / 8 cycles; no extra eat pulses.
- Scan fallback: max_retry=8, every draw occupied, only cell 12 free, last random cand=10 -> SCAN visits 11, then 12; food=12.
- Saturation and no space: score_a at 15 eats again -> stays 15 with eat_a pulse. cand_occ forced to 1 -> no_space=1, food_valid=0, later ticks ignored until rst.
- Async reset: assert rst between edges while busy in SCAN -> all outputs at reset values immediately; food=37, food_valid=1 after release.
